aes_key_schedule_seq: RTL and testbench
=======================================

Name: aes_key_schedule_seq

Overview:
- Iterative AES key-expansion engine that sits directly upstream of the cipher round datapath.
- Accepts a cipher key with a start pulse and computes the FIPS-197 word schedule one 32-bit word per cycle.
- Delivers the NR+1 128-bit round keys in order over a valid/ready stream.
- Replaces the flat, fully combinational expanded-key bus with a small sequential generator.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8.
- NR, 10, number of rounds; must equal NK+6.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new schedule; sampled only in IDLE.
- key_in  input  32*NK  cipher key; w[0] = key_in[32*NK-1 -: 32] (FIPS-197 byte order); sampled when start is accepted.
- busy  output  1  high while a schedule is in progress.
- rk_valid  output  1  rk_data/rk_index hold a round key.
- rk_ready  input  1  consumer accepts; transfer occurs when rk_valid && rk_ready.
- rk_data  output  128  round key; word 4r in [127:96], word 4r+3 in [31:0].
- rk_index  output  4  round number r, 0..NR.
- done  output  1  one-cycle pulse on the cycle the round-NR key transfers.

Behaviour:
- Reset: FSM=IDLE, busy=0, rk_valid=0, rk_data=0, rk_index=0, done=0, word counter=0, rcon=8'h01, assembly buffer empty.
- Reset mid-schedule aborts immediately; no further rk_valid until the next start.
- FSM IDLE -> RUN on start. RUN -> IDLE on the rk handshake with rk_index==NR; done pulses in that same cycle.
- start while busy: ignored; key_in is not resampled.
- Start acceptance (edge E0) captures key words into an NK-deep sliding window; busy=1 from E0.
- Word generation: one word per cycle, word k written at edge E(k+1), for k = 0..4*(NR+1)-1.
  - k < NK: w[k] comes from key_in.
  - k >= NK: temp = w[k-1].
  - If k mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon).
  - Else if NK==8 and k mod NK == 4: temp = SubWord(temp).
  - w[k] = w[k-NK] ^ temp.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36; xtime reduces with 8'h1b on MSB carry.
- SubWord uses four combinational AES S-box byte lookups; no pipeline stage.
- Assembly: words accumulate into a 3-word buffer. The 4th word goes together with the buffer directly into rk_data on the same edge, rk_valid=1, and rk_index is loaded with r.
- Latency: round 0 is valid after E4. With rk_ready held high, rk_valid is high one cycle in every four, and the final key is valid after E(4*NR+4).
- Backpressure: while rk_valid && !rk_ready, generation continues until the buffer holds 3 words, then stalls with no state change. rk_data and rk_index stay stable while rk_valid && !rk_ready.
- Simultaneous handshake and 4th-word completion in the same cycle: the new key loads into rk_data and rk_valid stays 1, with no bubble.
- After the round-NR transfer: rk_valid=0, busy=0, and rk_data holds its last value.
- The word counter never exceeds 4*(NR+1)-1; no wrap-around.

Test Plan:
1. NK=4, key 000102030405060708090a0b0c0d0e0f, rk_ready=1 -> rk0=000102030405060708090a0b0c0d0e0f after E4; rk1=d6aa74fdd2af72fadaa678f1d6ab76fe; rk10=13111d7fe3944a17f307a78b4d2b30c5 with done pulse; busy low the next cycle.
2. NK=4, key 2b7e151628aed2a6abf7158809cf4f3c -> rk10=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_index steps 0..10 with no gaps or repeats.
3. NK=6, key 000102…1617 -> rk12=a4970a331a78dc09c418c271e3a41d5d. NK=8, key 000102…1e1f -> rk14=24fc79ccbf0979e9371ac23c6d68de36.
4. Random rk_ready (about 30% high) with the test 1 key -> identical key sequence; rk_data/rk_index stable whenever rk_valid && !rk_ready; exactly 11 transfers; done on the last one.
5. start pulsed again at cycle 10 with a different key -> ignored; sequence matches test 1. rst asserted after rk3 transfers -> next cycle busy=0, rk_valid=0; a new start yields a correct rk0 after E4.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion: one schedule word per cycle, delivered as
// 128-bit round keys over a valid/ready stream.
module aes_key_schedule_seq #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [32*NK-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_data,
  output logic [3:0]       rk_index,
  output logic             done
);

  localparam int unsigned NW   = 4 * (NR + 1);
  localparam int unsigned KW   = $clog2(NW);
  localparam int unsigned MW   = $clog2(NK);
  localparam int unsigned HALF = NK / 2;

  // AES S-box, byte 8'h00 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [31:0]   win [NK];
  logic [31:0]   abuf [3];
  logic [1:0]    bcnt;
  logic [KW-1:0] wcnt;
  logic [MW-1:0] kmod;
  logic [7:0]    rcon;
  logic          gen_done;
  logic          xfer, step, load;
  logic          key_phase, rcon_step;
  logic [31:0]   sub_in, sub_out, temp, new_word;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sequencing: generation stalls only when the buffer is full and the key is blocked
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    xfer      = rk_valid && rk_ready;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        step = !gen_done && !((bcnt == 2'd3) && rk_valid && !rk_ready);
        load = step && (bcnt == 2'd3);
        if (xfer && (rk_index == 4'(NR))) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Next schedule word from the sliding window (win[0] = w[k-NK], win[NK-1] = w[k-1])
  always_comb begin
    key_phase = (wcnt < KW'(NK));
    sub_in    = (kmod == '0) ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
    sub_out   = sub_word(sub_in);
    temp      = win[NK-1];
    rcon_step = 1'b0;
    if (kmod == '0) begin
      temp      = sub_out ^ {rcon, 24'h0};
      rcon_step = !key_phase;
    end else if ((NK == 8) && (kmod == MW'(HALF))) begin
      temp = sub_out;
    end
    new_word = key_phase ? win[0] : (win[0] ^ temp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NK); i++) win[i] <= '0;
      for (int i = 0; i < 3; i++) abuf[i] <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      kmod     <= '0;
      rcon     <= 8'h01;
      gen_done <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        for (int i = 0; i < int'(NK); i++) win[i] <= key_in[32*(int'(NK)-i)-1 -: 32];
        bcnt     <= '0;
        wcnt     <= '0;
        kmod     <= '0;
        rcon     <= 8'h01;
        gen_done <= 1'b0;
      end
      if (step) begin
        // Key words rotate through the window unchanged, later words shift in
        for (int i = 0; i < int'(NK) - 1; i++) win[i] <= win[i+1];
        win[NK-1] <= new_word;
        if (wcnt == KW'(NW - 1)) gen_done <= 1'b1;
        else                     wcnt     <= wcnt + KW'(1);
        kmod <= (kmod == MW'(NK - 1)) ? '0 : kmod + MW'(1);
        if (rcon_step) rcon <= xtime(rcon);
        if (load) begin
          bcnt     <= '0;
          rk_data  <= {abuf[0], abuf[1], abuf[2], new_word};
          rk_index <= 4'(wcnt >> 2);
        end else begin
          abuf[bcnt] <= new_word;
          bcnt       <= bcnt + 2'd1;
        end
      end
      if (load)      rk_valid <= 1'b1;
      else if (xfer) rk_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: NK=4/6/8 instances checked against a
// field-arithmetic key-expansion model and published FIPS-197 vectors.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         rk_ready;
  logic         start_v [3];
  logic         busy_v  [3];
  logic         valid_v [3];
  logic         done_v  [3];
  logic [127:0] data_v  [3];
  logic [3:0]   idx_v   [3];
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];

  localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.NK(4), .NR(10)) u_nk4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key4), .busy(busy_v[0]),
    .rk_valid(valid_v[0]), .rk_ready(rk_ready), .rk_data(data_v[0]),
    .rk_index(idx_v[0]), .done(done_v[0]));

  aes_key_schedule_seq #(.NK(6), .NR(12)) u_nk6 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key6), .busy(busy_v[1]),
    .rk_valid(valid_v[1]), .rk_ready(rk_ready), .rk_data(data_v[1]),
    .rk_index(idx_v[1]), .done(done_v[1]));

  aes_key_schedule_seq #(.NK(8), .NR(14)) u_nk8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key8), .busy(busy_v[2]),
    .rk_valid(valid_v[2]), .rk_ready(rk_ready), .rk_data(data_v[2]),
    .rk_index(idx_v[2]), .done(done_v[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_ref(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  task automatic build_model(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = sub_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_ref(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_key(input int s, input logic [255:0] k);
    case (s)
      0:       key4 = k[127:0];
      1:       key6 = k[191:0];
      default: key8 = k;
    endcase
    build_model(4 + 2*s, k);
  endtask

  // One schedule on instance s; abort_after >= 0 resets once that many keys transferred
  task automatic run_sched(input int s, input int ready_pct, input bit glitch, input int abort_after);
    int nr, idx, n;
    bit held, seen;
    logic [127:0] hd;
    logic [3:0] hi;
    nr = 4 + 2*s + 6;
    idx = 0; n = 0; held = 1'b0; hd = '0; hi = '0;
    for (int i = 0; i < 15; i++) got_rk[i] = 'x;
    @(negedge clk);
    start_v[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[s] = 1'b0;
    chk("busy_after_start", 128'(busy_v[s]), 128'(1));
    while (idx <= nr && n < 3000) begin
      if (abort_after >= 0 && idx == abort_after) begin
        rst = 1'b1; rk_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 128'(busy_v[s]), 128'(0));
        chk("abort_valid", 128'(valid_v[s]), 128'(0));
        chk("abort_data", data_v[s], 128'(0));
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
          @(negedge clk);
          if (valid_v[s]) seen = 1'b1;
        end
        chk("abort_quiet", 128'(seen), 128'(0));
        return;
      end
      if (glitch && n == 10) begin start_v[s] = 1'b1; key4 = ~key4; end
      if (glitch && n == 11) start_v[s] = 1'b0;
      rk_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (valid_v[s]) begin
        if (held) begin
          chk("stall_data", data_v[s], hd);
          chk("stall_index", 128'(idx_v[s]), 128'(hi));
        end
        if (rk_ready) begin
          chk("rk_index", 128'(idx_v[s]), 128'(idx));
          chk("rk_data", data_v[s], exp_rk[idx]);
          chk("done", 128'(done_v[s]), 128'(idx == nr));
          if (ready_pct == 100) chk("latency", 128'(n), 128'(4*idx + 4));
          got_rk[idx] = data_v[s];
          idx++;
          held = 1'b0;
        end else begin
          chk("done_quiet", 128'(done_v[s]), 128'(0));
          held = 1'b1; hd = data_v[s]; hi = idx_v[s];
        end
      end else begin
        if (held) chk("valid_dropped", 128'(valid_v[s]), 128'(1));
        chk("done_quiet", 128'(done_v[s]), 128'(0));
        held = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("transfer_count", 128'(idx), 128'(nr + 1));
    chk("end_busy", 128'(busy_v[s]), 128'(0));
    chk("end_valid", 128'(valid_v[s]), 128'(0));
    chk("end_data_held", data_v[s], exp_rk[nr]);
  endtask

  initial begin
    logic [255:0] k;
    build_sbox();
    rst = 1'b1; rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy_v[0]), 128'(0));
    chk("rst_valid", 128'(valid_v[0]), 128'(0));
    chk("rst_data", data_v[0], 128'(0));
    chk("rst_index", 128'(idx_v[0]), 128'(0));
    chk("rst_done", 128'(done_v[0]), 128'(0));
    chk("rst_busy_nk6", 128'(busy_v[1]), 128'(0));
    chk("rst_busy_nk8", 128'(busy_v[2]), 128'(0));
    rst = 1'b0;

    load_key(0, KEY1);
    run_sched(0, 100, 1'b0, -1);
    chk("t1_rk0", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("t1_rk1", got_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("t1_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    load_key(0, 256'h2b7e151628aed2a6abf7158809cf4f3c);
    run_sched(0, 100, 1'b0, -1);
    chk("t2_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    load_key(1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
    run_sched(1, 100, 1'b0, -1);
    chk("t3_nk6_rk12", got_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);

    load_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    run_sched(2, 100, 1'b0, -1);
    chk("t3_nk8_rk14", got_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    load_key(0, KEY1);
    run_sched(0, 30, 1'b0, -1);
    chk("t4_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    load_key(0, KEY1);
    run_sched(0, 100, 1'b1, -1);
    chk("t5_glitch_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    load_key(0, KEY1);
    run_sched(0, 60, 1'b0, 4);
    run_sched(0, 100, 1'b0, -1);
    chk("t5_restart_rk0", got_rk[0], 128'h000102030405060708090a0b0c0d0e0f);

    for (int s = 0; s < 3; s++) begin
      repeat (2) begin
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        load_key(s, k);
        run_sched(s, 50, 1'b0, -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
